// File: rtl/irrigacao_pkg.sv
// Shared definitions for the irrigation system: flow-state encoding, default
// plant rates and sensor thresholds, and the level-to-sensor helper.
package irrigacao_pkg;

  // Flow state reported by the tank model on every tick
  typedef enum logic [1:0] {
    PARADO     = 2'd0,
    ENCHENDO   = 2'd1,
    ESVAZIANDO = 2'd2,
    EQUILIBRIO = 2'd3
  } estado_t;

  // Default tank geometry and sensor thresholds (units of level)
  localparam int NIVEL_MAX_PADRAO     = 100;
  localparam int NIVEL_INICIAL_PADRAO = 0;
  localparam int LIMIAR_BAIXA_PADRAO  = 10;
  localparam int LIMIAR_MEDIA_PADRAO  = 50;
  localparam int LIMIAR_ALTA_PADRAO   = 90;

  // Default flow rates (units per tick)
  localparam int TAXA_VE_PADRAO          = 5;
  localparam int TAXA_GOTEJAMENTO_PADRAO = 1;
  localparam int TAXA_ASPERSAO_PADRAO    = 3;

  // Default clock cycles per integration tick
  localparam int PRESCALER_PADRAO = 4;

  // Fixed inconsistent sensor pattern {Alta, Media, Baixa} used to provoke
  // the controller's error path
  localparam logic [2:0] SENSORES_FALHA = 3'b101;

  // Thermometer code {Alta, Media, Baixa} for a given level
  function automatic logic [2:0] termometro(input int nivel,
                                            input int lim_baixa,
                                            input int lim_media,
                                            input int lim_alta);
    logic [2:0] s;
    s[2] = (nivel >= lim_alta);
    s[1] = (nivel >= lim_media);
    s[0] = (nivel >= lim_baixa);
    return s;
  endfunction

endpackage

// File: rtl/modelo_caixa_if.sv
// Sensor/actuator bus between the irrigation controller and the tank model.
// The controller (master) drives the actuator commands and reads the level
// sensors; the plant (slave) does the opposite.
interface modelo_caixa_if;

  logic Ve;
  logic Gotejamento;
  logic Aspersao;
  logic Alta;
  logic Media;
  logic Baixa;

  modport master (
    output Ve,
    output Gotejamento,
    output Aspersao,
    input  Alta,
    input  Media,
    input  Baixa
  );

  modport slave (
    input  Ve,
    input  Gotejamento,
    input  Aspersao,
    output Alta,
    output Media,
    output Baixa
  );

endinterface

// File: rtl/divisor_tick.sv
// Prescaler for the tank model: counts 0..PRESCALER-1 and flags the last
// count as the integration tick. With PRESCALER=1 every cycle is a tick.
module divisor_tick #(
  parameter int PRESCALER = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CNT_W = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(PRESCALER - 1);
  localparam logic [CNT_W-1:0] UM     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick is decoded from the current count so it lines up with the wrap
  always_comb begin
    tick_o = (cnt_q == ULTIMO);
  end

  // Next count: wrap on the tick, otherwise advance
  always_comb begin
    cnt_d = cnt_q;
    if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + UM;
    end
  end

  // Counter register; reset restarts the prescaler phase
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/modelo_caixa.sv
// Behavioural water-tank plant: integrates the valve/drip/sprinkler commands
// into a clamped level once per prescaled tick and reports registered level
// sensors, flow state and overflow/underflow events.
// Optional feature: define MODELO_CAIXA_FALHA_EN to add the Forca_falha input
// that forces an inconsistent sensor pattern while level integration goes on.
module modelo_caixa
  import irrigacao_pkg::*;
#(
  parameter int NIVEL_MAX        = NIVEL_MAX_PADRAO,
  parameter int NIVEL_INICIAL    = NIVEL_INICIAL_PADRAO,
  parameter int LIMIAR_BAIXA     = LIMIAR_BAIXA_PADRAO,
  parameter int LIMIAR_MEDIA     = LIMIAR_MEDIA_PADRAO,
  parameter int LIMIAR_ALTA      = LIMIAR_ALTA_PADRAO,
  parameter int TAXA_VE          = TAXA_VE_PADRAO,
  parameter int TAXA_GOTEJAMENTO = TAXA_GOTEJAMENTO_PADRAO,
  parameter int TAXA_ASPERSAO    = TAXA_ASPERSAO_PADRAO,
  parameter int PRESCALER        = PRESCALER_PADRAO
) (
  input  logic                               clk,
  input  logic                               reset,
  modelo_caixa_if.slave                      bus,
`ifdef MODELO_CAIXA_FALHA_EN
  input  logic                               Forca_falha,
`endif
  output logic [$clog2(NIVEL_MAX+1)-1:0]     Nivel,
  output logic [1:0]                         Estado,
  output logic                               Transbordo,
  output logic                               Falta,
  output logic                               Transbordou
);

  // Level width and the signed working width that holds any candidate level
  localparam int W  = $clog2(NIVEL_MAX + 1);
  localparam int CW = W + 2;

  localparam logic signed [CW-1:0] TAXA_VE_S   = CW'(TAXA_VE);
  localparam logic signed [CW-1:0] TAXA_GOT_S  = CW'(TAXA_GOTEJAMENTO);
  localparam logic signed [CW-1:0] TAXA_ASP_S  = CW'(TAXA_ASPERSAO);
  localparam logic signed [CW-1:0] NIVEL_MAX_S = CW'(NIVEL_MAX);
  localparam logic [W-1:0]         NIVEL_MAX_W = W'(NIVEL_MAX);
  localparam logic [W-1:0]         NIVEL_INI_W = W'(NIVEL_INICIAL);

  logic                 tick_s;
  logic                 algum_cmd_s;
  logic signed [CW-1:0] delta_s;
  logic signed [CW-1:0] cand_s;

  logic [W-1:0] nivel_q;
  logic [W-1:0] nivel_d;
  logic         transbordo_q;
  logic         transbordo_d;
  logic         falta_q;
  logic         falta_d;
  logic         transbordou_q;
  logic         transbordou_d;
  estado_t      estado_q;
  estado_t      estado_d;
  logic [2:0]   sensores_q;
  logic [2:0]   sensores_d;

  divisor_tick #(
    .PRESCALER (PRESCALER)
  ) u_divisor_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick_s)
  );

  // Net flow for this cycle's commands and the resulting unclamped level
  always_comb begin
    delta_s     = '0;
    algum_cmd_s = bus.Ve | bus.Gotejamento | bus.Aspersao;
    if (bus.Ve) begin
      delta_s = delta_s + TAXA_VE_S;
    end else begin
      delta_s = delta_s;
    end
    if (bus.Gotejamento) begin
      delta_s = delta_s - TAXA_GOT_S;
    end else begin
      delta_s = delta_s;
    end
    if (bus.Aspersao) begin
      delta_s = delta_s - TAXA_ASP_S;
    end else begin
      delta_s = delta_s;
    end
    cand_s = $signed({2'b00, nivel_q}) + delta_s;
  end

  // Level update with clamping; a candidate exactly on a bound is not a clamp
  always_comb begin
    nivel_d       = nivel_q;
    transbordo_d  = 1'b0;
    falta_d       = 1'b0;
    transbordou_d = transbordou_q;
    if (tick_s) begin
      if (cand_s > NIVEL_MAX_S) begin
        nivel_d       = NIVEL_MAX_W;
        transbordo_d  = 1'b1;
        transbordou_d = 1'b1;
      end else if (cand_s[CW-1]) begin
        nivel_d = '0;
        falta_d = 1'b1;
      end else begin
        nivel_d = cand_s[W-1:0];
      end
    end else begin
      nivel_d = nivel_q;
    end
  end

  // Flow-state next state: decided from the sign of delta on each tick,
  // independent of whether the level ended up clamped
  always_comb begin
    estado_d = estado_q;
    if (tick_s) begin
      if (!algum_cmd_s) begin
        estado_d = PARADO;
      end else if (delta_s[CW-1]) begin
        estado_d = ESVAZIANDO;
      end else if (delta_s == '0) begin
        estado_d = EQUILIBRIO;
      end else begin
        estado_d = ENCHENDO;
      end
    end else begin
      estado_d = estado_q;
    end
  end

  // Sensor next value: thermometer of the registered level, or the forced
  // inconsistent pattern when fault injection is built in and requested
  always_comb begin
    sensores_d = termometro(32'(nivel_q), LIMIAR_BAIXA, LIMIAR_MEDIA, LIMIAR_ALTA);
`ifdef MODELO_CAIXA_FALHA_EN
    if (Forca_falha) begin
      sensores_d = SENSORES_FALHA;
    end else begin
      sensores_d = termometro(32'(nivel_q), LIMIAR_BAIXA, LIMIAR_MEDIA, LIMIAR_ALTA);
    end
`endif
  end

  // Flow-state register
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= PARADO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Level and event registers; reset wins over a coincident tick
  always_ff @(posedge clk) begin
    if (reset) begin
      nivel_q       <= NIVEL_INI_W;
      transbordo_q  <= 1'b0;
      falta_q       <= 1'b0;
      transbordou_q <= 1'b0;
    end else begin
      nivel_q       <= nivel_d;
      transbordo_q  <= transbordo_d;
      falta_q       <= falta_d;
      transbordou_q <= transbordou_d;
    end
  end

  // Sensor register; lags the level register by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      sensores_q <= 3'b000;
    end else begin
      sensores_q <= sensores_d;
    end
  end

  // Drive outputs straight from registers
  always_comb begin
    Nivel       = nivel_q;
    Estado      = estado_q;
    Transbordo  = transbordo_q;
    Falta       = falta_q;
    Transbordou = transbordou_q;
    bus.Alta    = sensores_q[2];
    bus.Media   = sensores_q[1];
    bus.Baixa   = sensores_q[0];
  end

endmodule

// File: doc/modelo_caixa.md
# modelo_caixa

Behavioural plant model of the water tank driven by the irrigation controller's actuator outputs. The block consumes `Ve`, `Gotejamento` and `Aspersao` and integrates them into a tank level on a prescaled tick. It produces the level sensor signals `Alta`, `Media` and `Baixa` that `sistema_irrigacao` consumes. It sits on the opposite side of the sensor/actuator interface, closing the loop for system-level simulation and FPGA demo boards.

## Interface
- `NIVEL_MAX`, default 100: full-tank level in units.
- `NIVEL_INICIAL`, default 0: level loaded on reset. Must be ≤ `NIVEL_MAX`.
- `LIMIAR_BAIXA`, default 10: level at or above which `Baixa`=1.
- `LIMIAR_MEDIA`, default 50: level at or above which `Media`=1.
- `LIMIAR_ALTA`, default 90: level at or above which `Alta`=1.
- `TAXA_VE`, default 5: units added per tick while `Ve`=1.
- `TAXA_GOTEJAMENTO`, default 1: units removed per tick while `Gotejamento`=1.
- `TAXA_ASPERSAO`, default 3: units removed per tick while `Aspersao`=1.
- `PRESCALER`, default 4: clock cycles per tick. Must be ≥ 1.
- `clk`  input  1: single clock, rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `Ve`  input  1: inlet valve command.
- `Gotejamento`  input  1: drip irrigation draw.
- `Aspersao`  input  1: sprinkler draw.
- `Alta`, `Media`, `Baixa`  output  1 each: registered level sensors.
- `Nivel`  output  $clog2(NIVEL_MAX+1): current level.
- `Estado`  output  2: flow state (see Operation).
- `Transbordo`  output  1: one-cycle pulse when the level is clamped at `NIVEL_MAX`.
- `Falta`  output  1: one-cycle pulse when the level is clamped at 0.
- `Transbordou`  output  1: sticky overflow flag. Cleared only by reset.

## Operation
- Prescaler counter runs 0..`PRESCALER`-1. `tick` is asserted on the cycle the counter equals `PRESCALER`-1. The counter then wraps to 0.
- Commands are sampled only on tick cycles. Command changes between ticks have no effect.
- On a tick, compute delta = `TAXA_VE`·Ve − `TAXA_GOTEJAMENTO`·Gotejamento − `TAXA_ASPERSAO`·Aspersao. Compute the candidate level in a signed width of W+2 bits, where W is the `Nivel` width.
- Clamping on the tick:
  - candidate > `NIVEL_MAX`: `Nivel`←`NIVEL_MAX`, `Transbordo`=1, `Transbordou`←1.
  - candidate < 0: `Nivel`←0, `Falta`=1.
  - otherwise: `Nivel`←candidate.
  - Candidate exactly equal to a bound is not a clamp and raises no pulse.
- Sensors are thermometer coded from the registered `Nivel`: `Baixa`=(Nivel≥LIMIAR_BAIXA), `Media`=(Nivel≥LIMIAR_MEDIA), `Alta`=(Nivel≥LIMIAR_ALTA). They are registered, so they lag `Nivel` by one cycle.
- `Estado` is updated on each tick from the sign of delta:
  - PARADO=0: no command active.
  - ENCHENDO=1: delta>0.
  - ESVAZIANDO=2: delta<0.
  - EQUILIBRIO=3: commands active and delta=0.
  - A clamped tick keeps the state implied by delta.

## Timing
- Reset values:
  - `Nivel`=`NIVEL_INICIAL`.
  - Prescaler=0.
  - `Estado`=PARADO.
  - `Alta`/`Media`/`Baixa`=0.
  - `Transbordo`/`Falta`/`Transbordou`=0.
- The first tick occurs `PRESCALER` cycles after `reset` deasserts.
- Latency:
  - Command sampled on tick edge → `Nivel`, `Estado` and pulses update at that edge.
  - Sensors update one cycle later.
- Reset asserted mid-count overrides everything in that cycle, including a coincident tick. The prescaler phase restarts.
- With `PRESCALER`=1, every cycle is a tick.

## Configuration
- `MODELO_CAIXA_FALHA_EN` defined: adds input `Forca_falha` (1 bit). While it is 1, the registered sensors output `Alta`=1, `Media`=0, `Baixa`=1 regardless of level. This is an inconsistent pattern used to exercise the controller's `Erro` path. `Nivel` integration continues unaffected. The pattern appears one cycle after `Forca_falha` rises, and normal sensors resume one cycle after it falls.
- Macro undefined: no port, no logic. Sensors always follow `Nivel`.

## Structure
- Package `irrigacao_pkg` holds:
  - the `Estado` encoding constants (PARADO, ENCHENDO, ESVAZIANDO, EQUILIBRIO);
  - the default rate and threshold constants shared with the controller benches.
- One sub-module, `divisor_tick`, holds the prescaler and emits `tick`. Everything else stays flat in `modelo_caixa`.

## Test plan
All scenarios use default parameters.
- Ve=1 held from reset → `Nivel` goes +5 every 4 cycles. `Baixa` rises 1 cycle after `Nivel`=10 (tick 2). `Media` at 50 (tick 10). `Alta` at 90 (tick 18). `Estado`=ENCHENDO.
- Ve=1 held for 21 ticks → `Nivel`=100 at tick 20. `Transbordo` pulses once at tick 21 only. `Transbordou` stays 1 until reset.
- `NIVEL_INICIAL`=2, Aspersao=1 → `Nivel`=0 after tick 1 with `Falta` pulse. Further ticks pulse `Falta` again. All sensors 0. `Estado`=ESVAZIANDO.
- Ve=Gotejamento=Aspersao=1 → `Nivel` +1 per tick, `Estado`=ENCHENDO. Ve=0 with Gotejamento=1, Aspersao=0 → −1 per tick.
- Reset pulsed for one cycle at prescaler count 2 while `Nivel`=35 → `Nivel`=0 and all outputs at reset values. Next tick is 4 cycles after release.
- `MODELO_CAIXA_FALHA_EN` with `Nivel`=20 and `Forca_falha`=1 → next cycle `Alta`=1, `Media`=0, `Baixa`=1. `Nivel` keeps integrating.
